// File: rtl/freq_gate_ctrl_if.sv
// Result handshake between the gate controller and the display formatter.
// The controller drives the latched result; the consumer answers with ready.
interface freq_gate_ctrl_if #(
    parameter int DIGITS_NUM = 6
);
    logic [4*DIGITS_NUM-1:0] result_out;
    logic                    overflow_out;
    logic                    result_valid_out;
    logic                    result_ready_in;
    logic                    dropped_out;

    modport master (
        output result_out,
        output overflow_out,
        output result_valid_out,
        output dropped_out,
        input  result_ready_in
    );

    modport slave (
        input  result_out,
        input  overflow_out,
        input  result_valid_out,
        input  dropped_out,
        output result_ready_in
    );
endinterface

// File: rtl/freq_gate_ctrl.sv
// Frequency-counter gate controller: synchronises the measured signal, gates
// count enables into a fixed window and hands the latched BCD result onward.
module freq_gate_ctrl #(
    parameter int DIGITS_NUM  = 6,
    parameter int GATE_CYCLES = 50000000,
    parameter int GATE_W      = 32
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    input  logic                    run_in,
    input  logic                    signal_in,
    output logic                    counter_clear_out,
    output logic                    counter_enable_out,
    input  logic [4*DIGITS_NUM-1:0] digits_in,
    input  logic                    carry_in,
    output logic                    gate_active_out,
    freq_gate_ctrl_if.master        res
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        GATE,
        SETTLE,
        LATCH
    } state_t;

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    state_t            state;
    state_t            state_next;
    logic              s1;
    logic              s2;
    logic              s3;
    logic              sig_edge;
    logic [GATE_W-1:0] gate_cnt;
    logic              settle_cnt;
    logic              sticky_ovf;

    assign sig_edge = s2 & ~s3;

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Dropping run_in aborts from any state; the abort overrides every transition.
    always_comb begin
        state_next        = state;
        counter_clear_out = 1'b0;
        gate_active_out   = 1'b0;
        case (state)
            IDLE: begin
                if (run_in) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                counter_clear_out = 1'b1;
                state_next        = GATE;
            end
            GATE: begin
                gate_active_out = 1'b1;
                if (gate_cnt == GATE_LAST) begin
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt) begin
                    state_next = LATCH;
                end
            end
            LATCH: begin
                state_next = CLEAR;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (!run_in) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            s1                   <= 1'b0;
            s2                   <= 1'b0;
            s3                   <= 1'b0;
            counter_enable_out   <= 1'b0;
            gate_cnt             <= '0;
            settle_cnt           <= 1'b0;
            sticky_ovf           <= 1'b0;
            res.result_out       <= '0;
            res.overflow_out     <= 1'b0;
            res.result_valid_out <= 1'b0;
            res.dropped_out      <= 1'b0;
        end else begin
            s1 <= signal_in;
            s2 <= s1;
            s3 <= s2;

            // The enable of the last gate cycle lands in SETTLE, which is why SETTLE exists.
            counter_enable_out <= sig_edge && (state == GATE) && run_in;

            if (state == CLEAR) begin
                gate_cnt <= '0;
            end else if (state == GATE) begin
                gate_cnt <= gate_cnt + 1'b1;
            end

            settle_cnt <= (state == SETTLE) ? ~settle_cnt : 1'b0;

            if (state == CLEAR) begin
                sticky_ovf <= 1'b0;
            end else if (carry_in && (state == GATE || state == SETTLE || state == LATCH)) begin
                sticky_ovf <= 1'b1;
            end

            // A pending result still unaccepted at LATCH is overwritten and reported as dropped.
            res.dropped_out <= 1'b0;
            if (state == LATCH && run_in) begin
                res.result_out       <= digits_in;
                res.overflow_out     <= sticky_ovf | carry_in;
                res.result_valid_out <= 1'b1;
                res.dropped_out      <= res.result_valid_out & ~res.result_ready_in;
            end else if (res.result_valid_out && res.result_ready_in) begin
                res.result_valid_out <= 1'b0;
            end
        end
    end

endmodule
